packet_receiver: RTL and testbench

PACKET_RECEIVER -- requirements
Module: packet_receiver

---
 rtl/packet_receiver_pkg.sv | 19 +
 rtl/packet_receiver_crc.sv | 24 ++
 rtl/packet_receiver.sv | 106 ++++++++++
 tb/tb_packet_receiver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/packet_receiver_pkg.sv
// Packet framing constants and receiver FSM encoding,
// shared by packet_receiver and packet_sender.
package packet_receiver_pkg;

  localparam int SRC_ID    = 0;
  localparam int DST_ID    = 1;
  localparam int SIZE      = 2;
  localparam int DATA      = 3;
  localparam int SIZE_BITS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DST,
    ST_SIZE,
    ST_DATA,
    ST_CRC
  } state_t;

endpackage

// File: rtl/packet_receiver_crc.sv
// Running XOR checksum; clear restarts the sum,
// and when enabled in the same cycle the byte seeds it.
module pkt_crc_acc #(
  parameter int UWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [UWIDTH-1:0] din,
  output logic [UWIDTH-1:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= '0;
    end else if (enable) begin
      crc <= (clear ? '0 : crc) ^ din;
    end else if (clear) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/packet_receiver.sv
// Parses SRC/DST/SIZE/DATA/CRC packets and writes them
// into one slot of a downstream buffer, committing on a good CRC.
module packet_receiver
  import packet_receiver_pkg::*;
#(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [UWIDTH-1:0]    packet_in,
  input  logic                 packet_valid,
  input  logic                 wfull,
  output logic                 wen,
  output logic [PTR_IN_SZ-1:0] waddr,
  output logic [UWIDTH-1:0]    wdata,
  output logic                 winc,
  output logic                 crc_err,
  output logic                 drop
);

  state_t                 state;
  state_t                 state_nx;
  logic [SIZE_BITS-1:0]   cnt;
  logic [SIZE_BITS-1:0]   cnt_nx;
  logic [PTR_IN_SZ-1:0]   off;
  logic [PTR_IN_SZ-1:0]   cur_off;
  logic                   full_q;
  logic                   blk;
  logic                   idle;
  logic                   abort;
  logic                   crc_hit;
  logic                   match;
  logic [UWIDTH-1:0]      crc;

  assign idle    = (state == ST_IDLE);
  assign abort   = !packet_valid && !idle;
  assign crc_hit = packet_valid && (state == ST_CRC);
  assign match   = (packet_in == crc);
  assign cur_off = idle ? PTR_IN_SZ'(SRC_ID) : off;
  // wfull only counts at SRC; the rest of the packet follows that decision
  assign blk     = idle ? wfull : full_q;

  pkt_crc_acc #(
    .UWIDTH(UWIDTH)
  ) u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (packet_valid && idle),
    .enable(packet_valid),
    .din   (packet_in),
    .crc   (crc)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!packet_valid) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_DST;
        ST_DST:  state_nx = ST_SIZE;
        ST_SIZE: begin
          cnt_nx   = packet_in[SIZE_BITS-1:0];
          state_nx = (cnt_nx != '0) ? ST_DATA : ST_CRC;
        end
        ST_DATA: begin
          cnt_nx = cnt - SIZE_BITS'(1);
          if (cnt == SIZE_BITS'(1)) state_nx = ST_CRC;
        end
        ST_CRC:  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      off     <= '0;
      full_q  <= 1'b0;
      wen     <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      winc    <= 1'b0;
      crc_err <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wen     <= packet_valid && !blk;
      winc    <= crc_hit && !full_q && match;
      crc_err <= abort || (crc_hit && !full_q && !match);
      drop    <= crc_hit && full_q;
      if (packet_valid) begin
        waddr <= cur_off;
        wdata <= packet_in;
        off   <= cur_off + PTR_IN_SZ'(1);
      end
      if (packet_valid && idle) full_q <= wfull;
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Scoreboard bench: the driver queues expected events,
// a monitor pops and compares them as the receiver emits them.
module tb_packet_receiver;

  localparam int EV_NONE = -1;
  localparam int EV_W    = 0;
  localparam int EV_INC  = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_DROP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] packet_in = '0;
  logic       packet_valid = 1'b0;
  logic       wfull = 1'b0;
  logic       wen;
  logic [3:0] waddr;
  logic [7:0] wdata;
  logic       winc;
  logic       crc_err;
  logic       drop;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  packet_receiver #(
    .UWIDTH(8),
    .PTR_IN_SZ(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .packet_in   (packet_in),
    .packet_valid(packet_valid),
    .wfull       (wfull),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .winc        (winc),
    .crc_err     (crc_err),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input int k,
                      input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int k, input logic [3:0] a,
                           input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
      failures++;
      $display("FAIL unexpected_ev cyc=%0d got kind=%0d addr=%0d data=%h required none",
               cyc, k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_W && (e.addr != a || e.data != d))) begin
        failures++;
        $display("FAIL event cyc=%0d got kind=%0d addr=%0d data=%h required kind=%0d addr=%0d data=%h",
                 cyc, k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_ev cyc=%0d got nothing required kind=%0d addr=%0d data=%h",
                 e.cyc, e.kind, e.addr, e.data);
      end
      if (wen)     expect_ev(EV_W, waddr, wdata);
      if (winc)    expect_ev(EV_INC, '0, '0);
      if (crc_err) expect_ev(EV_ERR, '0, '0);
      if (drop)    expect_ev(EV_DROP, '0, '0);
      if (winc || crc_err || drop) begin
        checks++;
        if (int'(winc) + int'(crc_err) + int'(drop) > 1) begin
          failures++;
          $display("FAIL exclusive cyc=%0d got winc=%b crc_err=%b drop=%b required one-hot",
                   cyc, winc, crc_err, drop);
        end
      end
    end
  end

  task automatic send_pkt(input logic full, input int res);
    for (int i = 0; i < pkt.size(); i++) begin
      @(negedge clk);
      packet_valid = 1'b1;
      packet_in    = pkt[i];
      wfull        = (i == 0) ? full : !full;
      if (!full) push(cyc + 1, EV_W, 4'(i), pkt[i]);
      if (i == pkt.size() - 1 && res != EV_NONE)
        push(cyc + 1, res, '0, '0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      packet_valid = 1'b0;
      wfull        = 1'b0;
    end
  endtask

  task automatic abort_pkt();
    @(negedge clk);
    packet_valid = 1'b0;
    push(cyc + 1, EV_ERR, '0, '0);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if ({wen, winc, crc_err, drop} != 4'b0 || waddr != '0 || wdata != '0) begin
      failures++;
      $display("FAIL %s got wen=%b winc=%b crc_err=%b drop=%b waddr=%0d wdata=%h required all 0",
               name, wen, winc, crc_err, drop, waddr, wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    idle(1);

    pkt = '{8'h01, 8'h02, 8'h02, 8'hAA, 8'h55, 8'hFE};
    send_pkt(1'b0, EV_INC);
    idle(1);

    pkt = '{8'h03, 8'h04, 8'h00, 8'h07};
    send_pkt(1'b0, EV_INC);
    idle(1);

    pkt = '{8'h01, 8'h02, 8'h02, 8'hAA, 8'h55, 8'hFF};
    send_pkt(1'b0, EV_ERR);
    idle(1);

    pkt = '{8'h01, 8'h02, 8'h02, 8'hAA, 8'h55, 8'hFE};
    send_pkt(1'b1, EV_DROP);
    idle(2);

    pkt = '{8'h01, 8'h02};
    send_pkt(1'b0, EV_NONE);
    abort_pkt();
    pkt = '{8'h03, 8'h04, 8'h00, 8'h07};
    send_pkt(1'b0, EV_INC);
    idle(1);

    pkt = '{8'h03, 8'h04, 8'h00, 8'h07};
    send_pkt(1'b0, EV_INC);
    pkt = '{8'h01, 8'h02, 8'h02, 8'hAA, 8'h55, 8'hFE};
    send_pkt(1'b0, EV_INC);
    pkt = '{8'h05, 8'h06, 8'hF9, 8'h33, 8'hC9};
    send_pkt(1'b0, EV_INC);
    pkt = '{8'h11, 8'h22, 8'h07, 8'h01, 8'h02, 8'h03,
            8'h04, 8'h05, 8'h06, 8'h07, 8'h34};
    send_pkt(1'b0, EV_INC);

    pkt = '{8'h01, 8'h02};
    send_pkt(1'b0, EV_NONE);
    @(negedge clk);
    rst          = 1'b0;
    packet_valid = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (2) @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b1;

    pkt = '{8'h03, 8'h04, 8'h00, 8'h07};
    send_pkt(1'b0, EV_INC);
    idle(4);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
